// File: rtl/peaks_pkg.sv
// -----------------------------------------------------------------------------
// peaks_pkg
// Shared definitions for the peak-block scheduler:
//   PEAKS, FREQ_WIDTH, FINAL_AMPL_WIDTH, TIME_COUNTER_WIDTH
//     - sizing of the peak block outputs; the values mirror the
//       global_variables.sv macro definitions used by the peak block.
//   IDX_W        - width of an index into the PEAKS entries.
//   state_t      - scheduler FSM states.
//   peak_tuple_t - one emitted {time, freq, ampl} tuple.
//   next_set / highest_set - index search helpers over an entry mask.
// -----------------------------------------------------------------------------
package peaks_pkg;

   localparam int PEAKS              = 6;
   localparam int FREQ_WIDTH         = 9;
   localparam int FINAL_AMPL_WIDTH   = 16;
   localparam int TIME_COUNTER_WIDTH = 16;

   localparam int IDX_W = (PEAKS > 1) ? $clog2(PEAKS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   // "time" is a reserved word, hence time_cnt for the timestamp field.
   typedef struct packed {
      logic [TIME_COUNTER_WIDTH-1:0] time_cnt;
      logic [FREQ_WIDTH-1:0]         freq;
      logic [FINAL_AMPL_WIDTH-1:0]   ampl;
   } peak_tuple_t;

   // Lowest set bit of mask strictly above position 'from' (from = -1 finds
   // the first set bit). Returns 0 when nothing qualifies.
   function automatic logic [IDX_W-1:0] next_set(input logic [PEAKS-1:0] mask,
                                                 input int               from);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = PEAKS - 1; i >= 0; i--) begin
         if (mask[i] && (i > from)) r = IDX_W'(i);
      end
      return r;
   endfunction

   // Highest set bit of mask (0 when the mask is empty).
   function automatic logic [IDX_W-1:0] highest_set(input logic [PEAKS-1:0] mask);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < PEAKS; i++) begin
         if (mask[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/peaks_drain.sv
// -----------------------------------------------------------------------------
// peaks_drain
// Snapshot and readout side of the scheduler. On 'load' it captures the peak
// block outputs together with the mask of entries to emit, then walks the
// emitted entries in index order, one per 'advance'.
//
// Optional feature macro: PEAKS_SKIP_ZERO_EN
//   defined   - entries with amplitude 0 are excluded from the mask.
//   undefined - every entry is emitted.
//
// Ports:
//   clk            in   clock
//   reset          in   synchronous, active-low
//   load           in   capture pk_* and the emit mask this cycle
//   advance        in   current entry accepted, move to the next one
//   pk_amplitudes  in   PEAKS x FINAL_AMPL_WIDTH live amplitudes
//   pk_freqs       in   PEAKS x FREQ_WIDTH live frequency bins
//   pk_counter     in   TIME_COUNTER_WIDTH live counter
//   tuple          out  snapshot entry at the current index
//   last           out  current index is the final emitted entry
//   any_emit       out  live inputs contain at least one entry to emit
// -----------------------------------------------------------------------------
module peaks_drain
   import peaks_pkg::*;
(
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      load,
   input  logic                                      advance,
   input  logic [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0]    pk_amplitudes,
   input  logic [PEAKS-1:0][FREQ_WIDTH-1:0]          pk_freqs,
   input  logic [TIME_COUNTER_WIDTH-1:0]             pk_counter,
   output peak_tuple_t                               tuple,
   output logic                                      last,
   output logic                                      any_emit
);

   logic [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0] snap_ampl;
   logic [PEAKS-1:0][FREQ_WIDTH-1:0]       snap_freq;
   logic [TIME_COUNTER_WIDTH-1:0]          snap_time;
   logic [PEAKS-1:0]                       mask;
   logic [PEAKS-1:0]                       live_mask;
   logic [IDX_W-1:0]                       idx;
   logic [IDX_W-1:0]                       last_idx;

   // Mask is derived from the live inputs so it is ready in the load cycle.
   always_comb begin
      live_mask = '0;
      for (int i = 0; i < PEAKS; i++) begin
`ifdef PEAKS_SKIP_ZERO_EN
         live_mask[i] = (pk_amplitudes[i] != '0);
`else
         live_mask[i] = 1'b1;
`endif
      end
   end

   assign any_emit = |live_mask;

   always_ff @(posedge clk) begin
      if (!reset) begin
         snap_ampl <= '0;
         snap_freq <= '0;
         snap_time <= '0;
         mask      <= '0;
         idx       <= '0;
         last_idx  <= '0;
      end else if (load) begin
         snap_ampl <= pk_amplitudes;
         snap_freq <= pk_freqs;
         snap_time <= pk_counter;
         mask      <= live_mask;
         idx       <= next_set(live_mask, -1);
         last_idx  <= highest_set(live_mask);
      end else if (advance) begin
         idx       <= next_set(mask, int'(idx));
      end
   end

   assign tuple.time_cnt = snap_time;
   assign tuple.freq     = snap_freq[idx];
   assign tuple.ampl     = snap_ampl[idx];
   assign last           = (idx == last_idx);

endmodule

// File: rtl/peaks_sched.sv
// -----------------------------------------------------------------------------
// peaks_sched
// Drives the peak block once per accepted FFT frame, waits for its outputs
// to settle, snapshots them and streams the peaks out as {time, freq, ampl}
// tuples. The first PRIME_FRAMES strobes after reset only fill the peak
// block's prev/curr/next pipeline and emit nothing.
//
// Optional feature macro: PEAKS_SKIP_ZERO_EN (zero-amplitude entries are not
// emitted; a frame with no nonzero entry returns to IDLE without beats).
//
// Parameters:
//   SETTLE_CYCLES  cycles waited after each strobe before the snapshot (1..15)
//   PRIME_FRAMES   strobes after reset that produce no tuples
//
// Ports:
//   CLOCK_50       in   clock
//   reset          in   synchronous, active-low
//   frame_valid    in   FFT frame present at the peak block input
//   frame_ready    out  scheduler accepts the frame (IDLE only)
//   pk_reset       out  registered active-high reset to the peak block
//   pk_valid_in    out  single-cycle strobe to the peak block
//   pk_amplitudes  in   peak block amplitudes_out
//   pk_freqs       in   peak block freqs_out
//   pk_counter     in   peak block counter_out
//   out_valid      out  tuple valid
//   out_ready      in   consumer accepts tuple
//   out_time       out  snapshot counter
//   out_freq       out  peak frequency bin
//   out_ampl       out  peak amplitude
//   out_last       out  final tuple of the frame
//   busy           out  FSM not in IDLE
// -----------------------------------------------------------------------------
module peaks_sched
   import peaks_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int PRIME_FRAMES  = 2
)(
   input  logic                                      CLOCK_50,
   input  logic                                      reset,
   input  logic                                      frame_valid,
   output logic                                      frame_ready,
   output logic                                      pk_reset,
   output logic                                      pk_valid_in,
   input  logic [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0]    pk_amplitudes,
   input  logic [PEAKS-1:0][FREQ_WIDTH-1:0]          pk_freqs,
   input  logic [TIME_COUNTER_WIDTH-1:0]             pk_counter,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [TIME_COUNTER_WIDTH-1:0]             out_time,
   output logic [FREQ_WIDTH-1:0]                     out_freq,
   output logic [FINAL_AMPL_WIDTH-1:0]               out_ampl,
   output logic                                      out_last,
   output logic                                      busy
);

   localparam int PW = (PRIME_FRAMES < 1) ? 1 : $clog2(PRIME_FRAMES + 1);

   state_t       state;
   logic [3:0]   settle_cnt;
   logic [PW-1:0] prime_cnt;
   logic         settle_last;
   logic         priming;
   logic         load;
   logic         advance;
   logic         drain_last;
   logic         any_emit;
   peak_tuple_t  tuple;

   assign settle_last = (state == ST_SETTLE) && (settle_cnt == 4'(SETTLE_CYCLES - 1));
   assign priming     = (int'(prime_cnt) < PRIME_FRAMES);
   assign load        = settle_last;
   assign advance     = out_valid && out_ready;

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         prime_cnt  <= '0;
         pk_reset   <= 1'b1;
      end else begin
         pk_reset <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (frame_valid && frame_ready) state <= ST_STROBE;
            end
            ST_STROBE: begin
               settle_cnt <= '0;
               state      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_last) begin
                  // Counter only moves while below PRIME_FRAMES, so it saturates.
                  if (priming) begin
                     prime_cnt <= prime_cnt + PW'(1);
                     state     <= ST_IDLE;
                  end else if (any_emit) begin
                     state <= ST_DRAIN;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            ST_DRAIN: begin
               if (out_ready && drain_last) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   peaks_drain u_drain (
      .clk           (CLOCK_50),
      .reset         (reset),
      .load          (load),
      .advance       (advance),
      .pk_amplitudes (pk_amplitudes),
      .pk_freqs      (pk_freqs),
      .pk_counter    (pk_counter),
      .tuple         (tuple),
      .last          (drain_last),
      .any_emit      (any_emit)
   );

   // pk_reset doubles as "still in reset" so frame_ready stays low until the
   // first edge that samples reset released.
   assign frame_ready = (state == ST_IDLE) && !pk_reset;
   assign pk_valid_in = (state == ST_STROBE);
   assign busy        = (state != ST_IDLE);
   assign out_valid   = (state == ST_DRAIN);
   assign out_last    = out_valid && drain_last;
   assign out_time    = out_valid ? tuple.time_cnt : '0;
   assign out_freq    = out_valid ? tuple.freq     : '0;
   assign out_ampl    = out_valid ? tuple.ampl     : '0;

endmodule

// File: tb/tb_peaks_sched.sv
`timescale 1ns/1ps
module tb_peaks_sched;
   import peaks_pkg::*;

   localparam int SETTLE_CYCLES = 2;
   localparam int PRIME_FRAMES  = 2;
`ifdef PEAKS_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct {
      longint t;
      longint f;
      longint a;
      longint last;
   } exp_t;

   logic                                   CLOCK_50 = 1'b0;
   logic                                   reset = 1'b0;
   logic                                   frame_valid = 1'b0;
   logic                                   frame_ready;
   logic                                   pk_reset;
   logic                                   pk_valid_in;
   logic [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0] amps = '0;
   logic [PEAKS-1:0][FREQ_WIDTH-1:0]       freqs = '0;
   logic [TIME_COUNTER_WIDTH-1:0]          cnt = '0;
   logic                                   out_valid;
   logic                                   out_ready = 1'b0;
   logic [TIME_COUNTER_WIDTH-1:0]          out_time;
   logic [FREQ_WIDTH-1:0]                  out_freq;
   logic [FINAL_AMPL_WIDTH-1:0]            out_ampl;
   logic                                   out_last;
   logic                                   busy;

   int n_checks = 0;
   int n_pass   = 0;
   int gcyc     = 0;
   int last_strobe = -1000;
   int prime_seen  = 0;
   int res_beats   = 0;
   int res_stalls  = 0;

   always #10 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) gcyc <= gcyc + 1;

   peaks_sched #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .PRIME_FRAMES  (PRIME_FRAMES)
   ) dut (
      .CLOCK_50      (CLOCK_50),
      .reset         (reset),
      .frame_valid   (frame_valid),
      .frame_ready   (frame_ready),
      .pk_reset      (pk_reset),
      .pk_valid_in   (pk_valid_in),
      .pk_amplitudes (amps),
      .pk_freqs      (freqs),
      .pk_counter    (cnt),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_time      (out_time),
      .out_freq      (out_freq),
      .out_ampl      (out_ampl),
      .out_last      (out_last),
      .busy          (busy)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic load_frame(input int a[6], input int f[6], input int c);
      for (int i = 0; i < PEAKS; i++) begin
         amps[i]  = FINAL_AMPL_WIDTH'(a[i]);
         freqs[i] = FREQ_WIDTH'(f[i]);
      end
      cnt = TIME_COUNTER_WIDTH'(c);
   endtask

   task automatic load_random();
      for (int i = 0; i < PEAKS; i++) begin
         amps[i]  = ($urandom_range(0, 2) == 0) ? '0 : FINAL_AMPL_WIDTH'($urandom_range(1, 65535));
         freqs[i] = FREQ_WIDTH'($urandom_range(0, 511));
      end
      cnt = TIME_COUNTER_WIDTH'($urandom_range(0, 65535));
   endtask

   // mode 0: out_ready always high; 1: random out_ready;
   // 2: out_ready low for 5 cycles while beat 2 is presented.
   // abort_after > 0: assert reset once that many beats have been accepted.
   task automatic run_frame(input int mode, input int abort_after);
      exp_t   q[$];
      exp_t   e;
      int     last_i, exp_cnt, n, t_acc, strobe_n, strobes, first_n, last_n, beats, stalls;
      bit     held;
      longint h_t, h_f, h_a, h_l;

      // Reference: priming frames emit nothing; otherwise every qualifying
      // entry in index order, last flag on the highest qualifying index.
      if (prime_seen < PRIME_FRAMES) begin
         prime_seen++;
      end else begin
         last_i = -1;
         for (int i = 0; i < PEAKS; i++)
            if (!SKIP || amps[i] != 0) last_i = i;
         for (int i = 0; i < PEAKS; i++) begin
            if (!SKIP || amps[i] != 0) begin
               e.t = cnt; e.f = freqs[i]; e.a = amps[i]; e.last = (i == last_i) ? 1 : 0;
               q.push_back(e);
            end
         end
      end
      exp_cnt = q.size();

      t_acc = -1; strobe_n = -1; strobes = 0; first_n = -1; last_n = -1;
      beats = 0; stalls = 0; held = 0; n = 0;
      h_t = 0; h_f = 0; h_a = 0; h_l = 0;
      while (1) begin
         @(negedge CLOCK_50);
         if (abort_after > 0 && beats >= abort_after) begin
            reset = 1'b0;
            res_beats = beats;
            return;
         end
         frame_valid = (t_acc < 0);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = !(beats == 1 && stalls < 5);
         endcase
         if (t_acc < 0 && frame_ready) t_acc = n;

         if (pk_valid_in) begin
            strobes++;
            if (strobe_n < 0) strobe_n = n;
            check("strobe_gap_ok", (gcyc - last_strobe >= SETTLE_CYCLES + 2) ? 1 : 0, 1);
            last_strobe = gcyc;
         end

         if (out_valid) begin
            if (first_n < 0) begin
               first_n = n;
               check("first_beat_latency", n - t_acc, 2 + SETTLE_CYCLES);
            end
            check("frame_ready_in_drain", frame_ready, 0);
            check("strobe_in_drain", pk_valid_in, 0);
            if (held) begin
               check("hold_time", out_time, h_t);
               check("hold_freq", out_freq, h_f);
               check("hold_ampl", out_ampl, h_a);
               check("hold_last", out_last, h_l);
            end
            if (out_ready) begin
               if (q.size() == 0) begin
                  check("unexpected_beat", 1, 0);
               end else begin
                  e = q.pop_front();
                  check("beat_time", out_time, e.t);
                  check("beat_freq", out_freq, e.f);
                  check("beat_ampl", out_ampl, e.a);
                  check("beat_last", out_last, e.last);
               end
               beats++;
               if (out_last) last_n = n;
            end else begin
               stalls++;
            end
            held = !out_ready;
            h_t = out_time; h_f = out_freq; h_a = out_ampl; h_l = out_last;
         end else begin
            held = 0;
         end

         if (t_acc >= 0 && n > t_acc && frame_ready) break;
         n++;
         if (n > 300) begin
            check("frame_timeout", 1, 0);
            break;
         end
      end

      check("strobe_count", strobes, 1);
      check("strobe_at_T+1", strobe_n - t_acc, 1);
      check("beat_count", beats, exp_cnt);
      check("beats_left", q.size(), 0);
      check("busy_idle", busy, 0);
      if (exp_cnt > 0) check("idle_after_last", n - last_n, 1);
      res_beats  = beats;
      res_stalls = stalls;
   endtask

   initial begin
      int da[6];
      int df[6];
      da = '{10, 20, 30, 40, 50, 60};
      df = '{3, 9, 15, 21, 27, 33};

      // Reset held low for three cycles.
      repeat (3) @(negedge CLOCK_50);
      check("rst_pk_reset", pk_reset, 1);
      check("rst_frame_ready", frame_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_time", out_time, 0);
      check("rst_busy", busy, 0);
      reset = 1'b1;
      @(negedge CLOCK_50);
      check("rel_pk_reset", pk_reset, 0);
      check("rel_frame_ready", frame_ready, 1);

      // Two priming frames, then the directed ramp frame.
      load_frame(da, df, 3);
      run_frame(0, 0);
      run_frame(0, 0);
      run_frame(0, 0);
      check("ramp_beats", res_beats, 6);

      // Same frame with a five-cycle stall on beat 2.
      run_frame(2, 0);
      check("stall_cycles", res_stalls, 5);

      // Sparse frame and all-zero frame.
      da = '{0, 5, 0, 0, 7, 0};
      load_frame(da, df, 77);
      run_frame(0, 0);
      check("sparse_beats", res_beats, SKIP ? 2 : 6);
      da = '{0, 0, 0, 0, 0, 0};
      load_frame(da, df, 5);
      run_frame(1, 0);
      check("zero_beats", res_beats, SKIP ? 0 : 6);

      for (int k = 0; k < 20; k++) begin
         load_random();
         run_frame(1, 0);
      end

      // Reset in the middle of a drain.
      da = '{10, 20, 30, 40, 50, 60};
      load_frame(da, df, 3);
      run_frame(0, 3);
      @(negedge CLOCK_50);
      out_ready   = 1'b0;
      frame_valid = 1'b0;
      check("abort_out_valid", out_valid, 0);
      check("abort_out_last", out_last, 0);
      check("abort_out_freq", out_freq, 0);
      check("abort_pk_reset", pk_reset, 1);
      check("abort_frame_ready", frame_ready, 0);
      reset = 1'b1;
      prime_seen = 0;
      @(negedge CLOCK_50);
      check("abort_rel_pk_reset", pk_reset, 0);
      check("abort_rel_frame_ready", frame_ready, 1);

      run_frame(0, 0);
      check("reprime1_beats", res_beats, 0);
      run_frame(1, 0);
      check("reprime2_beats", res_beats, 0);
      for (int k = 0; k < 5; k++) begin
         load_random();
         run_frame(1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
